// File: rtl/ledgame_ctrl.sv
// LED reaction game controller: lights a pseudo-random target LED each round and scores presses.
// Optional macro LEDGAME_SPEEDUP_EN shrinks the response window after every hit.
module ledgame_ctrl #(
  parameter int N_LEDS     = 4,
  parameter int WINDOW     = 20,
  parameter int GAP_CYCLES = 5,
  parameter int ROUNDS     = 10,
  parameter int SCORE_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_LEDS-1:0]   pressed,
  output logic [N_LEDS-1:0]   led,
  output logic [SCORE_W-1:0]  score,
  output logic                busy,
  output logic                done,
  output logic                hit,
  output logic                miss
);

  localparam int TGT_W = (N_LEDS > 2) ? $clog2(N_LEDS) : 1;
  localparam int TMR_W = $clog2(((WINDOW > GAP_CYCLES) ? WINDOW : GAP_CYCLES) + 1);
  localparam int RND_W = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, GAP, ARMED, DONE} state_t;

  state_t              state_q, state_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [RND_W-1:0]    round_q, round_d;
  logic [TGT_W-1:0]    target_q, target_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                hit_q, hit_d;
  logic                miss_q, miss_d;
  logic [TMR_W-1:0]    win;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    // Right-shifting Fibonacci form of taps 16,14,13,11
    lfsr_next = {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [N_LEDS-1:0] onehot(input logic [TGT_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    sat_inc = (s == '1) ? s : s + 1'b1;
  endfunction

`ifdef LEDGAME_SPEEDUP_EN
  localparam logic [TMR_W-1:0] WIN_STEP  = TMR_W'(WINDOW / 8);
  localparam logic [TMR_W-1:0] WIN_FLOOR = TMR_W'(WINDOW / 4);
  logic [TMR_W-1:0] win_q;
  logic             restart;

  assign restart = start && ((state_q == IDLE) || (state_q == DONE));
  assign win     = win_q;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      win_q <= TMR_W'(WINDOW);
    end else if (hit_d) begin
      win_q <= (win_q >= WIN_FLOOR + WIN_STEP) ? win_q - WIN_STEP : WIN_FLOOR;
    end
  end
`else
  assign win = TMR_W'(WINDOW);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      lfsr_q   <= 16'hACE1;
      timer_q  <= '0;
      round_q  <= '0;
      target_q <= '0;
      led_q    <= '0;
      score_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      timer_q  <= timer_d;
      round_q  <= round_d;
      target_q <= target_d;
      led_q    <= led_d;
      score_q  <= score_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  always_comb begin
    logic wrong, right, tout;
    state_d  = state_q;
    lfsr_d   = lfsr_next(lfsr_q);
    timer_d  = timer_q;
    round_d  = round_q;
    target_d = target_q;
    led_d    = led_q;
    score_d  = score_q;
    busy_d   = busy_q;
    done_d   = done_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    wrong    = |(pressed & ~onehot(target_q));
    right    = pressed[target_q];
    tout     = (timer_q == win);

    case (state_q)
      IDLE, DONE: begin
        led_d = '0;
        if (start) begin
          state_d = GAP;
          timer_d = TMR_W'(1);
          round_d = '0;
          score_d = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      GAP: begin
        led_d = '0;
        if (timer_q == TMR_W'(GAP_CYCLES)) begin
          state_d  = ARMED;
          timer_d  = TMR_W'(1);
          target_d = lfsr_q[TGT_W-1:0];
          led_d    = onehot(lfsr_q[TGT_W-1:0]);
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ARMED: begin
        // Wrong bits dominate a simultaneous correct press
        if (wrong) begin
          miss_d = 1'b1;
        end else if (right) begin
          hit_d   = 1'b1;
          score_d = sat_inc(score_q);
        end else if (tout) begin
          miss_d = 1'b1;
        end
        if (wrong || right || tout) begin
          led_d   = '0;
          round_d = round_q + 1'b1;
          timer_d = TMR_W'(1);
          if (round_q + 1'b1 == RND_W'(ROUNDS)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign led   = led_q;
  assign score = score_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign hit   = hit_q;
  assign miss  = miss_q;

endmodule
